// File: rtl/dac_sequencer.sv
// DAC update sequencer: paces WIDTH-bit codes to the DAC at a programmable
// rate, sourced either from a small streaming FIFO or an internal ramp.
module dac_sequencer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [DIV_W-1:0]       div,
    input  logic [WIDTH-1:0]       ramp_step,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic                   clr_underflow,
    output logic [WIDTH-1:0]       dac_code,
    output logic                   update,
    output logic                   underflow,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   dac_code_q, dac_code_d;
    logic               update_q, update_d;
    logic               underflow_q, underflow_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               tick_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_empty_s;

    assign in_ready     = (level_q < FULL_LVL);
    assign fifo_empty_s = (level_q == {LVL_W{1'b0}});
    assign push_s       = in_valid && in_ready;
    // Pop decision uses the pre-push level, so a same-cycle push never bypasses.
    assign pop_s        = tick_s && !mode && !fifo_empty_s;

    assign dac_code   = dac_code_q;
    assign update     = update_q;
    assign underflow  = underflow_q;
    assign busy       = (state_q == RUN);
    assign fifo_level = level_q;

    // Next-state logic: IDLE/RUN sequencing and the update-rate divider.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    count_d = {DIV_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (count_q == div) begin
                    tick_s  = 1'b1;
                    count_d = {DIV_W{1'b0}};
                end else begin
                    // Natural wrap at 2^DIV_W-1 when div was lowered below count.
                    count_d = count_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = {DIV_W{1'b0}};
            end
        endcase
    end

    // Output code, update pulse and sticky underflow; a set beats a clear.
    always_comb begin
        dac_code_d = dac_code_q;
        update_d   = 1'b0;
        if (clr_underflow) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
        if (tick_s) begin
            if (mode) begin
                dac_code_d = dac_code_q + ramp_step;
                update_d   = 1'b1;
            end else if (fifo_empty_s) begin
                underflow_d = 1'b1;
            end else begin
                dac_code_d = mem_q[rd_ptr_q];
                update_d   = 1'b1;
            end
        end else begin
            update_d = 1'b0;
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= {DIV_W{1'b0}};
            dac_code_q  <= {WIDTH{1'b0}};
            update_q    <= 1'b0;
            underflow_q <= 1'b0;
            level_q     <= {LVL_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dac_code_q  <= dac_code_d;
            update_q    <= update_d;
            underflow_q <= underflow_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_dac_sequencer.sv
// Self-checking bench for dac_sequencer: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model.
module tb_dac_sequencer;
    localparam int WIDTH = 10;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] ramp_step;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             clr_underflow;
    logic [WIDTH-1:0] dac_code;
    logic             update;
    logic             underflow;
    logic             busy;
    logic [2:0]       fifo_level;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    bit m_run = 1'b0;
    int m_cnt = 0;
    int m_q[$];
    int m_code = 0;
    bit m_upd = 1'b0;
    bit m_und = 1'b0;

    dac_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .div(div),
        .ramp_step(ramp_step), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clr_underflow(clr_underflow), .dac_code(dac_code),
        .update(update), .underflow(underflow), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Apply the specification's rules for one clock edge to the model.
    task automatic model_edge();
        bit tick;
        bit push;
        bit nund;
        tick = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_q.delete(); m_code = 0; m_upd = 1'b0; m_und = 1'b0;
        end else begin
            push = in_valid && (m_q.size() < DEPTH);
            if (!m_run) begin
                if (enable) begin m_run = 1'b1; m_cnt = 0; end
            end else if (!enable) begin
                m_run = 1'b0;
            end else if (m_cnt == int'(div)) begin
                tick = 1'b1; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1) % (1 << DIV_W);
            end
            m_upd = 1'b0;
            nund  = m_und && !clr_underflow;
            if (tick) begin
                if (mode) begin
                    m_code = (m_code + int'(ramp_step)) % (1 << WIDTH);
                    m_upd  = 1'b1;
                end else if (m_q.size() > 0) begin
                    m_code = m_q.pop_front();
                    m_upd  = 1'b1;
                end else begin
                    nund = 1'b1;
                end
            end
            m_und = nund;
            if (push) m_q.push_back(int'(in_data));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests_run++; if (dac_code !== 10'h000) begin tests_failed++; $display("FAIL reset_code: got %0h expected 0", dac_code); end
        tests_run++; if (update !== 1'b0) begin tests_failed++; $display("FAIL reset_update: got %0b expected 0", update); end
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_underflow: got %0b expected 0", underflow); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_fill_idle();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 10'h155; vals[1] = 10'h2AA; vals[2] = 10'h3FF;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            cycle();
            tests_run++; if (update !== 1'b0) begin tests_failed++; $display("FAIL fill_update: got %0b expected 0", update); end
        end
        in_valid = 1'b0;
        cycle();
        tests_run++; if (fifo_level !== 3'd3) begin tests_failed++; $display("FAIL fill_level: got %0d expected 3", fifo_level); end
        tests_run++; if (dac_code !== 10'h000) begin tests_failed++; $display("FAIL fill_code: got %0h expected 0", dac_code); end
    endtask

    task automatic test_stream();
        int exp_code;
        bit exp_upd;
        bit exp_und;
        div = 16'd3; mode = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cycle();
            exp_upd  = (k == 5) || (k == 9) || (k == 13);
            exp_code = (k < 5) ? 'h000 : (k < 9) ? 'h155 : (k < 13) ? 'h2AA : 'h3FF;
            exp_und  = (k >= 17);
            tests_run++; if (update !== exp_upd) begin tests_failed++; $display("FAIL stream_update k=%0d: got %0b expected %0b", k, update, exp_upd); end
            tests_run++; if (dac_code !== WIDTH'(exp_code)) begin tests_failed++; $display("FAIL stream_code k=%0d: got %0h expected %0h", k, dac_code, exp_code); end
            tests_run++; if (underflow !== exp_und) begin tests_failed++; $display("FAIL stream_underflow k=%0d: got %0b expected %0b", k, underflow, exp_und); end
        end
    endtask

    task automatic test_ramp();
        int exp_codes [5];
        exp_codes[0] = 'h0FF; exp_codes[1] = 'h1FF; exp_codes[2] = 'h2FF; exp_codes[3] = 'h3FF; exp_codes[4] = 'h0FF;
        mode = 1'b1; ramp_step = 10'h100; div = 16'd0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            tests_run++; if (dac_code !== WIDTH'(exp_codes[k])) begin tests_failed++; $display("FAIL ramp_code k=%0d: got %0h expected %0h", k, dac_code, exp_codes[k]); end
            tests_run++; if (update !== 1'b1) begin tests_failed++; $display("FAIL ramp_update k=%0d: got %0b expected 1", k, update); end
        end
        tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL ramp_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_back_to_back();
        int sb[$];
        int exp;
        int last_upd;
        bit seen_full;
        int n_upd;
        mode = 1'b0; div = 16'd7; clr_underflow = 1'b1;
        cycle();
        clr_underflow = 1'b0;
        in_valid = 1'b1; seen_full = 1'b0; last_upd = -1; n_upd = 0;
        for (int k = 0; k < 60; k++) begin
            in_data = WIDTH'($urandom);
            if (in_ready) sb.push_back(int'(in_data));
            cycle();
            tests_run++; if (in_ready !== (m_q.size() < DEPTH)) begin tests_failed++; $display("FAIL bp_in_ready k=%0d: got %0b expected %0b", k, in_ready, m_q.size() < DEPTH); end
            tests_run++; if (fifo_level !== 3'(m_q.size())) begin tests_failed++; $display("FAIL bp_level k=%0d: got %0d expected %0d", k, fifo_level, m_q.size()); end
            if (fifo_level == 3'd4) seen_full = 1'b1;
            if (update === 1'b1) begin
                n_upd++;
                exp = (sb.size() > 0) ? sb.pop_front() : -1;
                tests_run++; if (int'(dac_code) !== exp) begin tests_failed++; $display("FAIL bp_scoreboard k=%0d: got %0h expected %0h", k, dac_code, exp); end
                if (last_upd >= 0) begin
                    tests_run++; if (k - last_upd !== 8) begin tests_failed++; $display("FAIL bp_spacing k=%0d: got %0d expected 8", k, k - last_upd); end
                end
                last_upd = k;
            end
        end
        in_valid = 1'b0;
        tests_run++; if (seen_full !== 1'b1) begin tests_failed++; $display("FAIL bp_full_seen: got %0b expected 1", seen_full); end
        tests_run++; if (n_upd < 6) begin tests_failed++; $display("FAIL bp_update_count: got %0d expected at least 6", n_upd); end
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL bp_underflow: got %0b expected 0", underflow); end
    endtask

    task automatic test_pause_resume();
        logic [WIDTH-1:0] held;
        logic [2:0]       lvl;
        enable = 1'b0;
        cycle();
        held = dac_code; lvl = fifo_level;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL pause_busy: got %0b expected 0", busy); end
        tests_run++; if (fifo_level !== 3'(m_q.size())) begin tests_failed++; $display("FAIL pause_level: got %0d expected %0d", fifo_level, m_q.size()); end
        for (int k = 0; k < 5; k++) begin
            cycle();
            tests_run++; if (dac_code !== held || update !== 1'b0 || fifo_level !== lvl) begin tests_failed++; $display("FAIL pause_hold k=%0d: got code %0h upd %0b lvl %0d expected code %0h upd 0 lvl %0d", k, dac_code, update, fifo_level, held, lvl); end
        end
        enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            tests_run++; if (update !== (k == 9)) begin tests_failed++; $display("FAIL resume_update k=%0d: got %0b expected %0b", k, update, k == 9); end
        end
        tests_run++; if (dac_code !== WIDTH'(m_code)) begin tests_failed++; $display("FAIL resume_code: got %0h expected %0h", dac_code, m_code); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; in_valid = 1'b0;
        cycle();
        rst = 1'b0; enable = 1'b1; div = 16'd0; mode = 1'b0;
        cycle();
        cycle();
        div = 16'd200; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = WIDTH'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        tests_run++; if (fifo_level !== 3'd2 || underflow !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_setup: got lvl %0d und %0b busy %0b expected 2 1 1", fifo_level, underflow, busy); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests_run++; if (dac_code !== 10'h000) begin tests_failed++; $display("FAIL rstmid_code: got %0h expected 0", dac_code); end
        tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL rstmid_level: got %0d expected 0", fifo_level); end
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL rstmid_underflow: got %0b expected 0", underflow); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            enable        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            ramp_step     = WIDTH'($urandom);
            in_valid      = $urandom_range(0, 1) == 1;
            in_data       = WIDTH'($urandom);
            clr_underflow = ($urandom_range(0, 7) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            if (!m_run || m_cnt == 0) div = DIV_W'($urandom_range(0, 3));
            cycle();
            tests_run++; if (dac_code !== WIDTH'(m_code)) begin tests_failed++; $display("FAIL rnd_code k=%0d: got %0h expected %0h", k, dac_code, m_code); end
            tests_run++; if (update !== m_upd) begin tests_failed++; $display("FAIL rnd_update k=%0d: got %0b expected %0b", k, update, m_upd); end
            tests_run++; if (underflow !== m_und) begin tests_failed++; $display("FAIL rnd_underflow k=%0d: got %0b expected %0b", k, underflow, m_und); end
            tests_run++; if (busy !== m_run) begin tests_failed++; $display("FAIL rnd_busy k=%0d: got %0b expected %0b", k, busy, m_run); end
            tests_run++; if (fifo_level !== 3'(m_q.size())) begin tests_failed++; $display("FAIL rnd_level k=%0d: got %0d expected %0d", k, fifo_level, m_q.size()); end
            tests_run++; if (in_ready !== (m_q.size() < DEPTH)) begin tests_failed++; $display("FAIL rnd_in_ready k=%0d: got %0b expected %0b", k, in_ready, m_q.size() < DEPTH); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; div = 16'd0; ramp_step = 10'h000;
        in_valid = 1'b0; in_data = 10'h000; clr_underflow = 1'b0;
        cycle();
        cycle();
        test_reset();
        test_fill_idle();
        test_stream();
        test_ramp();
        test_back_to_back();
        test_pause_resume();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
